// File: rtl/ads1115_pkg.sv
// Shared constants, command encodings, scheduler states and the config-word builder for the ADS1115 scan scheduler.
// States for conversion polling exist only when ADS1115_POLL_OS_EN is defined.
package ads1115_pkg;

  localparam logic [6:0] I2C_ADDR    = 7'h48;
  localparam logic [7:0] REG_CONV    = 8'h00;
  localparam logic [7:0] REG_CFG     = 8'h01;
  localparam logic [2:0] MUX_SE_BASE = 3'b100;

  typedef enum logic [1:0] {
    OP_WR3 = 2'd0,
    OP_WR1 = 2'd1,
    OP_RD2 = 2'd2
  } cmd_op_e;

  typedef enum logic [3:0] {
    IDLE,
    CFG_REQ,
    CFG_WAIT,
    CONV,
    PTR_REQ,
    PTR_WAIT,
    RD_REQ,
    RD_WAIT,
    STORE
`ifdef ADS1115_POLL_OS_EN
    ,
    POLL_PTR_REQ,
    POLL_PTR_WAIT,
    POLL_RD_REQ,
    POLL_RD_WAIT
`endif
  } state_e;

  // OS=1 starts a single shot, MODE=1 single-shot, comparator queue disabled
  function automatic logic [15:0] cfg_word(input logic [1:0] ch,
                                           input logic [2:0] pga,
                                           input logic [2:0] dr);
    return {1'b1, MUX_SE_BASE | {1'b0, ch}, pga, 1'b1, dr, 5'b00011};
  endfunction

endpackage

// File: rtl/ads1115_ch_rr.sv
// Channel pointer register with round-robin pick of the next enabled channel.
// sel snaps to the lowest enabled channel >= ptr; adv moves strictly past ptr (wrapping 3->0).
module ads1115_ch_rr
  import ads1115_pkg::*;
#(
  parameter logic [3:0] CH_MASK = 4'b1111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic       adv,
  output logic [1:0] ptr
);

  logic [1:0] ptr_cur;
  logic [1:0] ptr_nxt;

  // Descending scan so the smallest offset from start wins
  function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] idx;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

  always_comb begin
    ptr_cur = pick(ptr, CH_MASK);
    ptr_nxt = pick(ptr + 2'd1, CH_MASK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= 2'd0;
    else if (adv) ptr <= ptr_nxt;
    else if (sel) ptr <= ptr_cur;
  end

endmodule

// File: rtl/ads1115_scan_sched.sv
// Round-robin single-shot scan of ADS1115 AIN0..AIN3 through a transaction-level I2C engine.
// Define ADS1115_POLL_OS_EN to replace the fixed conversion wait by OS-bit polling with timeout.
module ads1115_scan_sched
  import ads1115_pkg::*;
#(
  parameter int unsigned CONV_WAIT_CYC = 400000,
  parameter logic [3:0]  CH_MASK       = 4'b1111,
  parameter logic [2:0]  PGA           = 3'b010,
  parameter logic [2:0]  DR            = 3'b100,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [23:0]        cmd_data,
  input  logic               rsp_valid,
  input  logic               rsp_nack,
  input  logic [15:0]        rsp_data,
  output logic               sample_valid,
  output logic [1:0]         sample_ch,
  output logic signed [15:0] sample_data,
  output logic               busy,
  output logic               err_nack
);

  localparam int          RW        = $clog2(MAX_RETRY + 2);
  localparam logic [31:0] CONV_LOAD = 32'(CONV_WAIT_CYC - 1);

  state_e          state_q, state_d, nack_ret;
  logic [31:0]     tmr_q, tmr_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            err_q, err_d;
  logic            en_q;
  logic            sel, adv, cap, nack_evt, skip;
  logic [1:0]      ptr;

  ads1115_ch_rr #(.CH_MASK(CH_MASK)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (sel),
    .adv   (adv),
    .ptr   (ptr)
  );

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    retry_d   = retry_q;
    err_d     = err_q;
    sel       = 1'b0;
    adv       = 1'b0;
    cap       = 1'b0;
    nack_evt  = 1'b0;
    skip      = 1'b0;
    nack_ret  = IDLE;
    cmd_valid = 1'b0;
    cmd_op    = OP_WR3;
    cmd_data  = 24'h0;

    if (enable && !en_q) err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (CH_MASK != 4'b0000)) begin
          sel     = 1'b1;
          state_d = CFG_REQ;
        end
      end
      CFG_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WR3;
        cmd_data  = {REG_CFG, cfg_word(ptr, PGA, DR)};
        if (cmd_ready) state_d = CFG_WAIT;
      end
      CFG_WAIT: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            nack_evt = 1'b1;
            nack_ret = CFG_REQ;
          end else begin
            retry_d = '0;
            tmr_d   = CONV_LOAD;
`ifdef ADS1115_POLL_OS_EN
            state_d = POLL_PTR_REQ;
`else
            state_d = CONV;
`endif
          end
        end
      end
      CONV: begin
        if (tmr_q == 32'd0) state_d = PTR_REQ;
        else                tmr_d   = tmr_q - 32'd1;
      end
      PTR_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WR1;
        cmd_data  = {REG_CONV, 16'h0000};
        if (cmd_ready) state_d = PTR_WAIT;
      end
      PTR_WAIT: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            nack_evt = 1'b1;
            nack_ret = PTR_REQ;
          end else begin
            retry_d = '0;
            state_d = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_RD2;
        if (cmd_ready) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            nack_evt = 1'b1;
            nack_ret = RD_REQ;
          end else begin
            retry_d = '0;
            cap     = 1'b1;
            state_d = STORE;
          end
        end
      end
      STORE: begin
        adv     = 1'b1;
        state_d = enable ? CFG_REQ : IDLE;
      end
`ifdef ADS1115_POLL_OS_EN
      // Timer runs across the whole poll loop; expiry is only acted on between transactions
      POLL_PTR_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WR1;
        cmd_data  = {REG_CFG, 16'h0000};
        if (tmr_q != 32'd0) tmr_d = tmr_q - 32'd1;
        if (cmd_ready) state_d = POLL_PTR_WAIT;
      end
      POLL_PTR_WAIT: begin
        if (tmr_q != 32'd0) tmr_d = tmr_q - 32'd1;
        if (rsp_valid) begin
          if (rsp_nack) begin
            nack_evt = 1'b1;
            nack_ret = POLL_PTR_REQ;
          end else begin
            retry_d = '0;
            state_d = POLL_RD_REQ;
          end
        end
      end
      POLL_RD_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = OP_RD2;
        if (tmr_q != 32'd0) tmr_d = tmr_q - 32'd1;
        if (cmd_ready) state_d = POLL_RD_WAIT;
      end
      POLL_RD_WAIT: begin
        if (tmr_q != 32'd0) tmr_d = tmr_q - 32'd1;
        if (rsp_valid) begin
          if (rsp_nack) begin
            nack_evt = 1'b1;
            nack_ret = POLL_RD_REQ;
          end else begin
            retry_d = '0;
            if (rsp_data[15])         state_d = PTR_REQ;
            else if (tmr_q == 32'd0)  skip    = 1'b1;
            else                      state_d = POLL_PTR_REQ;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (nack_evt) begin
      if (retry_q >= RW'(MAX_RETRY)) begin
        skip = 1'b1;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = nack_ret;
      end
    end

    // Give up on this channel and move on
    if (skip) begin
      err_d   = 1'b1;
      retry_d = '0;
      adv     = 1'b1;
      state_d = enable ? CFG_REQ : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tmr_q       <= 32'd0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      en_q        <= 1'b0;
      sample_ch   <= 2'd0;
      sample_data <= 16'sd0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      err_q   <= err_d;
      en_q    <= enable;
      if (cap) begin
        sample_ch   <= ptr;
        sample_data <= rsp_data;
      end
    end
  end

  assign sample_valid = (state_q == STORE);
  assign busy         = (state_q != IDLE);
  assign err_nack     = err_q;

endmodule
